csr_timer_bank: RTL and testbench

Parametrised bank of NTIMER independent countdown timers exposed through the CSR access port, generalising the single LoongArch TCFG/TVAL/TICLR timer to N channels of configurable width. It sits beside the CSR file, shares its instruction-access bus (csr_num/csr_we/csr_wmask/csr_wvalue), and drives one pending-interrupt line per channel into ESTAT.IS. A debug freeze input halts all counters.

---
 rtl/csr_timer_bank.sv | 109 ++++++++++
 tb/tb_csr_timer_bank.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/csr_timer_bank.sv
// rtl/csr_timer_bank.sv - bank of NTIMER countdown timers behind the CSR access port
// Optional free-running stable counter: define TIMER_STABLE_CNT_EN.
module csr_timer_bank #(
  parameter int          NTIMER   = 2,
  parameter int          CNT_W    = 32,
  parameter logic [13:0] BASE_NUM = 14'h041
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [13:0]       csr_num,
  input  logic              csr_we,
  input  logic [31:0]       csr_wmask,
  input  logic [31:0]       csr_wvalue,
  output logic [31:0]       csr_rvalue,
  input  logic              freeze,
  output logic [NTIMER-1:0] timer_int,
  output logic              timer_int_any,
  output logic [63:0]       stable_cnt
);

  localparam logic [CNT_W-1:0] CNT_STOP = '1;

  logic [NTIMER-1:0] en, periodic, pending;
  logic [CNT_W-3:0]  init_val [NTIMER];
  logic [CNT_W-1:0]  cnt      [NTIMER];

  logic [13:0] off;
  logic        hit;
  assign off = csr_num - BASE_NUM;
  assign hit = (csr_num >= BASE_NUM) && (off < 14'(4 * NTIMER));

  logic [NTIMER-1:0] ch_hit, tcfg_we, ticlr_we, adv, expire;
  logic [31:0]       tcfg_old [NTIMER];
  logic [31:0]       tcfg_new [NTIMER];

  always_comb begin
    for (int i = 0; i < NTIMER; i++) begin
      ch_hit[i]                 = hit && (off[4:2] == 3'(i));
      tcfg_old[i]               = '0;
      tcfg_old[i][CNT_W-1:2]    = init_val[i];
      tcfg_old[i][1]            = periodic[i];
      tcfg_old[i][0]            = en[i];
      tcfg_new[i]               = (csr_wmask & csr_wvalue) | (~csr_wmask & tcfg_old[i]);
      tcfg_we[i]                = csr_we && ch_hit[i] && (off[1:0] == 2'd0);
      ticlr_we[i]               = csr_we && ch_hit[i] && (off[1:0] == 2'd3)
                                  && csr_wmask[0] && csr_wvalue[0];
      // all-ones is the parked value of a fired one-shot, so it never advances
      adv[i]                    = en[i] && !freeze && (cnt[i] != CNT_STOP);
      expire[i]                 = adv[i] && (cnt[i] == '0);
    end
  end

  always_comb begin
    csr_rvalue = '0;
    for (int i = 0; i < NTIMER; i++) begin
      if (ch_hit[i]) begin
        case (off[1:0])
          2'd0:    csr_rvalue = tcfg_old[i];
          2'd1:    csr_rvalue[CNT_W-1:0] = cnt[i];
          default: csr_rvalue = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      en       <= '0;
      periodic <= '0;
      pending  <= '0;
      for (int i = 0; i < NTIMER; i++) begin
        init_val[i] <= '0;
        cnt[i]      <= CNT_STOP;
      end
    end else begin
      for (int i = 0; i < NTIMER; i++) begin
        // a set in the same cycle as a clear wins
        pending[i] <= expire[i] | (pending[i] & ~ticlr_we[i]);
        if (tcfg_we[i]) begin
          en[i]       <= tcfg_new[i][0];
          periodic[i] <= tcfg_new[i][1];
          init_val[i] <= tcfg_new[i][CNT_W-1:2];
          if (tcfg_new[i][0])
            cnt[i] <= {tcfg_new[i][CNT_W-1:2], 2'b00};
        end else if (adv[i]) begin
          if (cnt[i] == '0)
            cnt[i] <= periodic[i] ? {init_val[i], 2'b00} : CNT_STOP;
          else
            cnt[i] <= cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  assign timer_int     = pending;
  assign timer_int_any = |pending;

`ifdef TIMER_STABLE_CNT_EN
  logic [63:0] stable_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) stable_q <= '0;
    else         stable_q <= stable_q + 64'd1;
  end
  assign stable_cnt = stable_q;
`else
  assign stable_cnt = '0;
`endif

endmodule

// File: tb/tb_csr_timer_bank.sv
// tb/tb_csr_timer_bank.sv - directed self-checking bench for csr_timer_bank
module tb_csr_timer_bank;

  logic        clk;
  logic        resetn;
  logic [13:0] csr_num;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic [31:0] csr_rvalue;
  logic        freeze;
  logic [1:0]  timer_int;
  logic        timer_int_any;
  logic [63:0] stable_cnt;

  int errors = 0;
  int checks = 0;

  localparam logic [13:0] CH0_TCFG  = 14'h041;
  localparam logic [13:0] CH0_TVAL  = 14'h042;
  localparam logic [13:0] CH0_RSV   = 14'h043;
  localparam logic [13:0] CH0_TICLR = 14'h044;
  localparam logic [13:0] CH1_TCFG  = 14'h045;
  localparam logic [13:0] CH1_TVAL  = 14'h046;
  localparam logic [13:0] CH1_TICLR = 14'h048;

  csr_timer_bank #(.NTIMER(2), .CNT_W(32), .BASE_NUM(14'h041)) dut (
    .clk(clk), .resetn(resetn), .csr_num(csr_num), .csr_we(csr_we),
    .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .csr_rvalue(csr_rvalue),
    .freeze(freeze), .timer_int(timer_int), .timer_int_any(timer_int_any),
    .stable_cnt(stable_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [13:0] num, output logic [31:0] v);
    csr_num = num;
    #1;
    v = csr_rvalue;
  endtask

  task automatic wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
    csr_num    = num;
    csr_wmask  = mask;
    csr_wvalue = val;
    csr_we     = 1'b1;
    @(posedge clk);
    #1;
    csr_we     = 1'b0;
    csr_wmask  = '0;
    csr_wvalue = '0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    resetn = 1'b0;
    step(3);
    #4 resetn = 1'b1;
    step(5);
`ifdef TIMER_STABLE_CNT_EN
    checks++; if (stable_cnt !== 64'd5) begin errors++; $display("FAIL stable_cnt got=%0d exp=5", stable_cnt); end
`else
    checks++; if (stable_cnt !== 64'd0) begin errors++; $display("FAIL stable_cnt got=%0d exp=0", stable_cnt); end
`endif
    rd(CH0_TVAL, v);
    checks++; if (v !== 32'hffffffff) begin errors++; $display("FAIL reset_tval0 got=%h exp=ffffffff", v); end
    rd(CH1_TVAL, v);
    checks++; if (v !== 32'hffffffff) begin errors++; $display("FAIL reset_tval1 got=%h exp=ffffffff", v); end
    rd(CH0_TCFG, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_tcfg0 got=%h exp=0", v); end
    checks++; if (timer_int !== 2'b00 || timer_int_any !== 1'b0) begin errors++; $display("FAIL reset_int got=%b/%b exp=00/0", timer_int, timer_int_any); end
    rd(14'h040, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL unmapped_lo got=%h exp=0", v); end
    rd(14'h049, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL unmapped_hi got=%h exp=0", v); end
    step(1);
  endtask

  task automatic test_oneshot;
    logic [31:0] v;
    wr(CH0_TCFG, 32'hffffffff, 32'h00000009);
    for (int k = 8; k >= 0; k--) begin
      rd(CH0_TVAL, v);
      checks++; if (v !== 32'(k) || timer_int[0] !== 1'b0) begin errors++; $display("FAIL oneshot_count tval=%h int=%b exp=%h/0", v, timer_int[0], k); end
      step(1);
    end
    rd(CH0_TVAL, v);
    checks++; if (v !== 32'hffffffff || timer_int[0] !== 1'b1 || timer_int_any !== 1'b1) begin errors++; $display("FAIL oneshot_fire tval=%h int=%b exp=ffffffff/1", v, timer_int[0]); end
    step(2);
    rd(CH0_TVAL, v);
    checks++; if (v !== 32'hffffffff) begin errors++; $display("FAIL oneshot_hold got=%h exp=ffffffff", v); end
    wr(CH0_TICLR, 32'h1, 32'h1);
    checks++; if (timer_int[0] !== 1'b0) begin errors++; $display("FAIL oneshot_clear got=%b exp=0", timer_int[0]); end
  endtask

  task automatic test_periodic;
    logic [31:0] v;
    wr(CH1_TCFG, 32'hffffffff, 32'h00000007);
    step(4);
    rd(CH1_TVAL, v);
    checks++; if (v !== 32'h0 || timer_int[1] !== 1'b0) begin errors++; $display("FAIL periodic_zero tval=%h int=%b exp=0/0", v, timer_int[1]); end
    step(1);
    rd(CH1_TVAL, v);
    checks++; if (v !== 32'h4 || timer_int[1] !== 1'b1) begin errors++; $display("FAIL periodic_reload tval=%h int=%b exp=4/1", v, timer_int[1]); end
    wr(CH1_TICLR, 32'h1, 32'h1);
    rd(CH1_TVAL, v);
    checks++; if (v !== 32'h3 || timer_int[1] !== 1'b0) begin errors++; $display("FAIL periodic_clear tval=%h int=%b exp=3/0", v, timer_int[1]); end
    step(3);
    rd(CH1_TVAL, v);
    checks++; if (v !== 32'h0 || timer_int[1] !== 1'b0) begin errors++; $display("FAIL periodic_zero2 tval=%h int=%b exp=0/0", v, timer_int[1]); end
    wr(CH1_TICLR, 32'h1, 32'h1);
    rd(CH1_TVAL, v);
    checks++; if (v !== 32'h4 || timer_int[1] !== 1'b1) begin errors++; $display("FAIL periodic_set_wins tval=%h int=%b exp=4/1", v, timer_int[1]); end
    wr(CH1_TCFG, 32'h1, 32'h0);
    wr(CH1_TICLR, 32'h1, 32'h1);
    rd(CH1_TCFG, v);
    checks++; if (v !== 32'h6 || timer_int !== 2'b00) begin errors++; $display("FAIL periodic_stop tcfg=%h int=%b exp=6/00", v, timer_int); end
  endtask

  task automatic test_masked;
    logic [31:0] v;
    wr(CH0_TCFG, 32'hffffffff, 32'h00000029);
    rd(CH0_TVAL, v);
    checks++; if (v !== 32'd40) begin errors++; $display("FAIL masked_load got=%0d exp=40", v); end
    step(5);
    wr(CH0_TCFG, 32'h1, 32'h0);
    rd(CH0_TVAL, v);
    checks++; if (v !== 32'd35) begin errors++; $display("FAIL masked_freeze got=%0d exp=35", v); end
    rd(CH0_TCFG, v);
    checks++; if (v !== 32'h28) begin errors++; $display("FAIL masked_tcfg got=%h exp=28", v); end
    wr(CH0_TVAL, 32'hffffffff, 32'h0);
    step(3);
    rd(CH0_TVAL, v);
    checks++; if (v !== 32'd35) begin errors++; $display("FAIL tval_readonly got=%0d exp=35", v); end
    rd(CH0_RSV, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reserved got=%h exp=0", v); end
  endtask

  task automatic test_freeze;
    logic [31:0] v;
    wr(CH0_TCFG, 32'hffffffff, 32'h0000000d);
    step(2);
    freeze = 1'b1;
    step(10);
    rd(CH0_TVAL, v);
    checks++; if (v !== 32'd10) begin errors++; $display("FAIL freeze_hold got=%0d exp=10", v); end
    freeze = 1'b0;
    step(1);
    rd(CH0_TVAL, v);
    checks++; if (v !== 32'd9) begin errors++; $display("FAIL freeze_resume got=%0d exp=9", v); end
    step(9);
    freeze = 1'b1;
    step(3);
    rd(CH0_TVAL, v);
    checks++; if (v !== 32'd0 || timer_int[0] !== 1'b0) begin errors++; $display("FAIL freeze_at_zero tval=%h int=%b exp=0/0", v, timer_int[0]); end
    freeze = 1'b0;
    step(1);
    rd(CH0_TVAL, v);
    checks++; if (v !== 32'hffffffff || timer_int[0] !== 1'b1) begin errors++; $display("FAIL freeze_release tval=%h int=%b exp=ffffffff/1", v, timer_int[0]); end
    wr(CH0_TICLR, 32'h1, 32'h1);
  endtask

  task automatic test_back_to_back;
    logic [31:0] v;
    wr(CH0_TCFG, 32'hffffffff, 32'h00000003);
    rd(CH0_TVAL, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL init0_tval got=%h exp=0", v); end
    wr(CH0_TCFG, 32'hffffffff, 32'h00000005);
    rd(CH0_TVAL, v);
    checks++; if (v !== 32'h4 || timer_int[0] !== 1'b1) begin errors++; $display("FAIL write_on_expiry tval=%h int=%b exp=4/1", v, timer_int[0]); end
  endtask

  task automatic test_async_reset;
    logic [31:0] v;
    wr(CH1_TCFG, 32'hffffffff, 32'h00000003);
    step(2);
    #2 resetn = 1'b0;
    rd(CH1_TVAL, v);
    checks++; if (timer_int !== 2'b00 || timer_int_any !== 1'b0 || stable_cnt !== 64'd0) begin errors++; $display("FAIL async_rst_int got=%b/%b/%0d exp=00/0/0", timer_int, timer_int_any, stable_cnt); end
    checks++; if (v !== 32'hffffffff) begin errors++; $display("FAIL async_rst_tval got=%h exp=ffffffff", v); end
    #1 resetn = 1'b1;
    step(4);
    rd(CH0_TVAL, v);
    checks++; if (v !== 32'hffffffff || timer_int !== 2'b00) begin errors++; $display("FAIL post_rst_idle tval=%h int=%b exp=ffffffff/00", v, timer_int); end
  endtask

  initial begin
    resetn     = 1'b0;
    csr_num    = '0;
    csr_we     = 1'b0;
    csr_wmask  = '0;
    csr_wvalue = '0;
    freeze     = 1'b0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_masked();
    test_freeze();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
